// File: rtl/plic_target_arbiter.sv
// PLIC target arbiter: sequential one-source-per-cycle scan selecting, per target,
// the highest-priority pending and enabled source, with claim-hazard suppression.
module plic_target_arbiter #(
  parameter int PLIC_SOURCE_COUNT   = 8,
  parameter int PLIC_TARGET_COUNT   = 2,
  parameter int PLIC_SOURCE_WIDTH   = 4,
  parameter int PLIC_PRIORITY_WIDTH = 3
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [PLIC_SOURCE_COUNT-1:0]                           irq_pending_i,
  input  logic [PLIC_SOURCE_COUNT-1:0][PLIC_PRIORITY_WIDTH-1:0]  irq_priority_i,
  input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_COUNT-1:0]    irq_enable_i,
  input  logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIORITY_WIDTH-1:0]  threshold_i,
  input  logic [PLIC_TARGET_COUNT-1:0]                           claim_req_i,
  output logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]    claim_idx_o,
  output logic [PLIC_TARGET_COUNT-1:0]                           irq_target_o
);

  localparam int SCAN_W = (PLIC_SOURCE_COUNT > 1) ? $clog2(PLIC_SOURCE_COUNT) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(PLIC_SOURCE_COUNT - 1);

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]   best_id_q, best_id_d;
  logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIORITY_WIDTH-1:0] best_prio_q, best_prio_d;
  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]   claim_idx_q, claim_idx_d;
  logic [PLIC_TARGET_COUNT-1:0]                          irq_q, irq_d;
  logic [PLIC_TARGET_COUNT-1:0]                          dirty_q, dirty_d;

  logic                                                  last_s;
  logic [PLIC_SOURCE_WIDTH-1:0]                          cur_id_s;
  logic [PLIC_PRIORITY_WIDTH-1:0]                        cur_prio_s;
  logic [PLIC_TARGET_COUNT-1:0]                          take_s;
  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]   acc_id_s;
  logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIORITY_WIDTH-1:0] acc_prio_s;

  assign last_s     = (scan_q == SCAN_LAST);
  assign cur_id_s   = PLIC_SOURCE_WIDTH'(scan_q) + PLIC_SOURCE_WIDTH'(1);
  assign cur_prio_s = irq_priority_i[scan_q];

  always_comb begin
    scan_d = last_s ? '0 : scan_q + SCAN_W'(1);
  end

  // Accumulator including this cycle's candidate; strict '>' keeps the lowest ID on ties.
  always_comb begin
    for (int t = 0; t < PLIC_TARGET_COUNT; t++) begin
      take_s[t] = irq_pending_i[scan_q] & irq_enable_i[t][scan_q] &
                  (cur_prio_s != '0) & (cur_prio_s > best_prio_q[t]);
      if (take_s[t]) begin
        acc_id_s[t]   = cur_id_s;
        acc_prio_s[t] = cur_prio_s;
      end else begin
        acc_id_s[t]   = best_id_q[t];
        acc_prio_s[t] = best_prio_q[t];
      end
    end
  end

  always_comb begin
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    claim_idx_d = claim_idx_q;
    irq_d       = irq_q;
    dirty_d     = dirty_q;
    for (int t = 0; t < PLIC_TARGET_COUNT; t++) begin
      if (claim_req_i[t]) begin
        // Claimed source is still pending this cycle, so the running scan is stale.
        best_id_d[t]   = '0;
        best_prio_d[t] = '0;
        claim_idx_d[t] = '0;
        irq_d[t]       = 1'b0;
        dirty_d[t]     = 1'b1;
      end else if (last_s) begin
        best_id_d[t]   = '0;
        best_prio_d[t] = '0;
        if (dirty_q[t]) begin
          dirty_d[t] = 1'b0;
        end else if (acc_prio_s[t] > threshold_i[t]) begin
          claim_idx_d[t] = acc_id_s[t];
          irq_d[t]       = 1'b1;
        end else begin
          claim_idx_d[t] = '0;
          irq_d[t]       = 1'b0;
        end
      end else begin
        best_id_d[t]   = acc_id_s[t];
        best_prio_d[t] = acc_prio_s[t];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q      <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      claim_idx_q <= '0;
      irq_q       <= '0;
      dirty_q     <= '0;
    end else begin
      scan_q      <= scan_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      claim_idx_q <= claim_idx_d;
      irq_q       <= irq_d;
      dirty_q     <= dirty_d;
    end
  end

  assign claim_idx_o  = claim_idx_q;
  assign irq_target_o = irq_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Scoreboard bench for plic_target_arbiter: per-cycle expected outputs from a
// scan-level reference model, checked by an independent monitor.
module tb_plic_target_arbiter;
  localparam int NS = 8;
  localparam int NT = 2;
  localparam int SW = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0]         pend;
  logic [NS-1:0][PW-1:0] prio;
  logic [NT-1:0][NS-1:0] en;
  logic [NT-1:0][PW-1:0] thr;
  logic [NT-1:0]         claim;
  logic [NT-1:0][SW-1:0] idx;
  logic [NT-1:0]         irq;

  always #5 clk = ~clk;

  plic_target_arbiter #(
    .PLIC_SOURCE_COUNT(NS), .PLIC_TARGET_COUNT(NT),
    .PLIC_SOURCE_WIDTH(SW), .PLIC_PRIORITY_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .irq_pending_i(pend), .irq_priority_i(prio),
    .irq_enable_i(en), .threshold_i(thr), .claim_req_i(claim),
    .claim_idx_o(idx), .irq_target_o(irq)
  );

  typedef struct packed {
    logic [NT-1:0][SW-1:0] idx;
    logic [NT-1:0]         irq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int                    si;
  logic [NT-1:0][SW-1:0] m_idx;
  logic [NT-1:0]         m_irq;
  logic [NT-1:0]         m_dirty;
  logic [NS-1:0]         clr_next;
  logic [NS-1:0]         gw_clr;
  logic [NS-1:0]         snap_pend [NS];
  logic [NS-1:0][PW-1:0] snap_prio [NS];
  logic [NT-1:0][NS-1:0] snap_en   [NS];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    si = 0; m_idx = '0; m_irq = '0; m_dirty = '0; clr_next = '0; gw_clr = '0;
  endtask

  // Highest candidate priority seen over the scan, then the lowest ID holding it.
  function automatic void winner(input int t, output int id, output int p);
    p = 0; id = 0;
    for (int s = 0; s < NS; s++)
      if (snap_pend[s][s] && snap_en[s][t][s] && int'(snap_prio[s][s]) > p)
        p = int'(snap_prio[s][s]);
    if (p > 0)
      for (int s = NS - 1; s >= 0; s--)
        if (snap_pend[s][s] && snap_en[s][t][s] && int'(snap_prio[s][s]) == p)
          id = s + 1;
  endfunction

  task automatic step(input logic [NS-1:0] p, input logic [NS-1:0][PW-1:0] pr,
                      input logic [NT-1:0][NS-1:0] e, input logic [NT-1:0][PW-1:0] th,
                      input logic [NT-1:0] clm);
    int wid, wp;
    exp_t x;
    @(negedge clk);
    gw_clr   = gw_clr | clr_next;
    clr_next = '0;
    pend = p & ~gw_clr; prio = pr; en = e; thr = th; claim = clm;
    snap_pend[si] = pend; snap_prio[si] = pr; snap_en[si] = e;
    for (int t = 0; t < NT; t++) begin
      if (clm[t]) begin
        if (m_idx[t] != '0) clr_next[int'(m_idx[t]) - 1] = 1'b1;
        m_idx[t] = '0; m_irq[t] = 1'b0; m_dirty[t] = 1'b1;
      end else if (si == NS - 1) begin
        if (m_dirty[t]) m_dirty[t] = 1'b0;
        else begin
          winner(t, wid, wp);
          if (wp > int'(th[t])) begin m_idx[t] = SW'(wid); m_irq[t] = 1'b1; end
          else begin m_idx[t] = '0; m_irq[t] = 1'b0; end
        end
      end
    end
    x.idx = m_idx; x.irq = m_irq;
    exp_q.push_back(x);
    si = (si + 1) % NS;
  endtask

  task automatic run_scan(input logic [NS-1:0] p, input logic [NS-1:0][PW-1:0] pr,
                          input logic [NT-1:0][NS-1:0] e, input logic [NT-1:0][PW-1:0] th,
                          input logic [NT-1:0] cmask, input int cat, input bit keep, input int ncyc);
    if (!keep) gw_clr = '0;
    for (int c = 0; c < ncyc; c++)
      step(p, pr, e, th, (c == cat) ? cmask : '0);
  endtask

  // monitor: compares DUT outputs after each edge against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int t = 0; t < NT; t++) begin
          check($sformatf("claim_idx[%0d]", t), int'(idx[t]), int'(e.idx[t]));
          check($sformatf("irq_target[%0d]", t), int'(irq[t]), int'(e.irq[t]));
        end
      end
    end
  end

  initial begin
    logic [NS-1:0][PW-1:0] pr;
    logic [NT-1:0][NS-1:0] e;
    logic [NT-1:0][PW-1:0] th;
    logic [NT-1:0]         cm;
    rst = 1'b1; pend = '0; prio = '0; en = '0; thr = '0; claim = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_idx", int'(idx), 0);
    check("reset_irq", int'(irq), 0);
    rst = 1'b0;

    // all pending, then async reset mid-scan
    for (int s = 0; s < NS; s++) pr[s] = PW'(s % 7 + 1);
    e = '1; th = '0;
    run_scan(8'hFF, pr, e, th, '0, NS, 1'b0, NS);
    run_scan(8'hFF, pr, e, th, '0, NS, 1'b0, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset_idx", int'(idx), 0);
    check("async_reset_irq", int'(irq), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single source ID 3, prio 2, target 0 only
    pr = '0; pr[2] = 3'd2; e = '0; e[0] = 8'b0000_0100; th = '0;
    run_scan(8'b0000_0100, pr, e, th, '0, NS, 1'b0, 2 * NS);

    // tie between IDs 2 and 5, then ID 5 raised
    pr = '0; pr[1] = 3'd4; pr[4] = 3'd4; e = '0; e[0] = 8'b0001_0010;
    run_scan(8'b0001_0010, pr, e, th, '0, NS, 1'b0, 2 * NS);
    pr[4] = 3'd5;
    run_scan(8'b0001_0010, pr, e, th, '0, NS, 1'b0, 2 * NS);

    // threshold equal, then lowered
    pr = '0; pr[3] = 3'd3; e = '0; e[0] = 8'b0000_1000; th = '0; th[0] = 3'd3;
    run_scan(8'b0000_1000, pr, e, th, '0, NS, 1'b0, 2 * NS);
    th[0] = 3'd2;
    run_scan(8'b0000_1000, pr, e, th, '0, NS, 1'b0, 2 * NS);

    // claim mid-scan, target 1 kept busy on ID 1
    pr = '0; pr[2] = 3'd2; pr[5] = 3'd5; pr[0] = 3'd1;
    e = '0; e[0] = 8'b0010_0100; e[1] = 8'b0000_0001; th = '0;
    run_scan(8'b0010_0101, pr, e, th, '0, NS, 1'b0, NS);
    run_scan(8'b0010_0101, pr, e, th, 2'b01, 3, 1'b0, NS);
    run_scan(8'b0010_0101, pr, e, th, '0, NS, 1'b1, 2 * NS);
    // claim on the commit cycle
    run_scan(8'b0010_0101, pr, e, th, 2'b01, NS - 1, 1'b0, NS);
    run_scan(8'b0010_0101, pr, e, th, '0, NS, 1'b1, 3 * NS);

    // randomized scans with occasional claims
    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < NS; s++) pr[s] = PW'($urandom_range(0, 7));
      e  = NT * NS'($urandom);
      e  = {NS'($urandom), NS'($urandom)};
      th = {PW'($urandom_range(0, 4)), PW'($urandom_range(0, 4))};
      cm = ($urandom_range(0, 2) == 0) ? NT'($urandom_range(1, 3)) : '0;
      run_scan(NS'($urandom), pr, e, th, cm, int'($urandom_range(0, NS - 1)),
               1'b0, NS);
    end

    @(posedge clk);
    #3 check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
